// File: rtl/score_game_ctrl.sv
// Game-level sequencer: IDLE/PLAY/OVER flow, one BCD score increment per pipe,
// best-score tracking and registered selection of the value shown on the display.
module score_game_ctrl #(
  parameter int unsigned ALT_CYCLES = 50_000_000,
  parameter logic [15:0] SCORE_MAX  = 16'h9999
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pass,
  input  logic        crash,
  output logic [1:0]  state,
  output logic [15:0] score,
  output logic [15:0] best,
  output logic [15:0] disp_val,
  output logic        show_best,
  output logic        new_best,
  output logic        score_evt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int unsigned      CNT_W    = (ALT_CYCLES > 1) ? $clog2(ALT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Add one to a 4-digit BCD word; a digit at 9 wraps to 0 and carries.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [15:0]      score_r, score_nxt_s;
  logic [15:0]      best_r, best_nxt_s;
  logic             new_best_r, new_best_nxt_s;
  logic             evt_r, evt_nxt_s;
  logic             pass_q_r, start_q_r;
  logic [CNT_W-1:0] alt_cnt_r, alt_cnt_nxt_s;
  logic             show_best_r, show_best_nxt_s;
  logic [15:0]      disp_val_r, disp_val_nxt_s;
  logic             pass_rise_s, start_rise_s;

  assign pass_rise_s  = pass & ~pass_q_r;
  assign start_rise_s = start & ~start_q_r;

  // Game flow, scoring and best-score update; crash outranks a same-cycle pass edge.
  always_comb begin
    state_nxt_s    = state_r;
    score_nxt_s    = score_r;
    best_nxt_s     = best_r;
    new_best_nxt_s = new_best_r;
    evt_nxt_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_rise_s) begin
          state_nxt_s    = ST_PLAY;
          score_nxt_s    = 16'h0000;
          new_best_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (crash) begin
          state_nxt_s = ST_OVER;
          // BCD words order correctly under a plain unsigned compare.
          if (score_r > best_r) begin
            best_nxt_s     = score_r;
            new_best_nxt_s = 1'b1;
          end else begin
            best_nxt_s = best_r;
          end
        end else if (pass_rise_s) begin
          evt_nxt_s = 1'b1;
          if (score_r == SCORE_MAX) begin
            score_nxt_s = SCORE_MAX;
          end else begin
            score_nxt_s = bcd_inc(score_r);
          end
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (start_rise_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OVER;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Display source: best in IDLE, score in PLAY, alternating in OVER starting with score.
  always_comb begin
    alt_cnt_nxt_s   = CNT_ZERO;
    show_best_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        show_best_nxt_s = 1'b1;
      end
      ST_PLAY: begin
        show_best_nxt_s = 1'b0;
      end
      ST_OVER: begin
        if (alt_cnt_r == CNT_LAST) begin
          alt_cnt_nxt_s   = CNT_ZERO;
          show_best_nxt_s = ~show_best_r;
        end else begin
          alt_cnt_nxt_s   = alt_cnt_r + CNT_ONE;
          show_best_nxt_s = show_best_r;
        end
      end
      default: begin
        show_best_nxt_s = 1'b0;
      end
    endcase
    disp_val_nxt_s = show_best_nxt_s ? best_r : score_r;
  end

  // State, score, best, edge history and display registers.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      score_r     <= 16'h0000;
      best_r      <= 16'h0000;
      new_best_r  <= 1'b0;
      evt_r       <= 1'b0;
      pass_q_r    <= 1'b0;
      start_q_r   <= 1'b0;
      alt_cnt_r   <= CNT_ZERO;
      show_best_r <= 1'b0;
      disp_val_r  <= 16'h0000;
    end else begin
      state_r     <= state_nxt_s;
      score_r     <= score_nxt_s;
      best_r      <= best_nxt_s;
      new_best_r  <= new_best_nxt_s;
      evt_r       <= evt_nxt_s;
      pass_q_r    <= pass;
      start_q_r   <= start;
      alt_cnt_r   <= alt_cnt_nxt_s;
      show_best_r <= show_best_nxt_s;
      disp_val_r  <= disp_val_nxt_s;
    end
  end

  assign state     = state_r;
  assign score     = score_r;
  assign best      = best_r;
  assign disp_val  = disp_val_r;
  assign show_best = show_best_r;
  assign new_best  = new_best_r;
  assign score_evt = evt_r;

endmodule

// File: doc/score_game_ctrl.md
Name: score_game_ctrl

Overview:
- Game-level sequencer for the score datapath.
- Owns the IDLE/PLAY/OVER flow and converts the per-frame gap-pass level into exactly one score increment per pipe.
- Keeps a 4-digit BCD score and a best score.
- Selects what the 4-digit 7-segment display shows. Its output feeds the DispNum HEXS input and the game logic.

Parameters:
ALT_CYCLES, 50_000_000, system_clk cycles between score/best display alternation in OVER (bench uses 8)
SCORE_MAX, 16'h9999, BCD saturation value of score

Ports:
system_clk  in  1  system clock; all logic rises on this edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  start/restart button level, already debounced and synchronous to system_clk
pass  in  1  level, high while bird is inside a pipe gap; synchronous to system_clk
crash  in  1  level, high while bird collides with pipe or ground
state  out  2  0=IDLE, 1=PLAY, 2=OVER (3 never produced)
score  out  16  current score, 4 BCD digits
best  out  16  best score since reset, 4 BCD digits
disp_val  out  16  value for display (BCD)
show_best  out  1  high when disp_val is the best score
new_best  out  1  high in OVER when this run set a new best
score_evt  out  1  one-cycle pulse on every score increment (sound/flash trigger)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; score=0, best=0.
  - show_best=0, new_best=0, score_evt=0.
  - pass_q=0, start_q=0, alt counter=0.
  - All of these take effect immediately, mid-run included.
- Registered history: pass_q and start_q follow pass and start every cycle.
  - pass_rise = pass & ~pass_q.
  - start_rise = start & ~start_q.
- FSM, evaluated every cycle:
  - IDLE: on start_rise -> PLAY. Same edge: score=0, new_best=0.
  - PLAY, crash=1 -> OVER. crash has priority over a simultaneous pass_rise: no increment, no score_evt.
  - PLAY, crash=0 and pass_rise=1 -> score increments by 1 in BCD; score_evt=1 for exactly that following cycle.
  - PLAY, start is ignored.
  - OVER: on start_rise -> IDLE. crash and pass are ignored.
- Increment latency:
  - pass rises in sample cycle N; score is updated at the end of cycle N and visible in cycle N+1 together with score_evt.
  - pass held high for many cycles gives one increment only.
  - pass must return low for at least 1 cycle before the next increment.
- BCD increment:
  - A digit at 9 becomes 0 and carries into the next digit.
  - score==SCORE_MAX stays 9999 (saturates). score_evt still pulses so the event is not lost.
- Best update, on the PLAY->OVER transition edge:
  - If score > best (unsigned compare of the BCD words, which is valid for BCD), then best=score and new_best=1.
  - Otherwise best and new_best are unchanged.
  - best is never cleared except by reset.
- Display selection:
  - IDLE: disp_val=best, show_best=1.
  - PLAY: disp_val=score, show_best=0.
  - OVER: the alt counter counts 0..ALT_CYCLES-1; on wrap show_best toggles. disp_val=best when show_best=1, else score. Entering OVER forces the counter to 0 and show_best to 0, so score is shown first.
  - Leaving OVER: counter held at 0.
- disp_val and show_best are registered, one cycle after the state/score they reflect.
- new_best is cleared on the IDLE->PLAY edge.

Test Plan:
- Reset with start pulse: reset=0 for 3 cycles, then 1; pulse start 1 cycle -> state 0 then 1 the next cycle, score=0, disp_val=0, show_best=0.
- Pass hold: in PLAY, pass high 20 cycles, low 5, high 20 -> score=0x0002, exactly two 1-cycle score_evt pulses, each the cycle after the pass rise.
- BCD carry and saturation: preload via 99 passes -> score=0x0099; 1 more -> 0x0100. Continue to 0x9999; 1 more pass -> score stays 0x9999 and score_evt pulses.
- Crash with pass, then best update: crash=1 in the same cycle as pass_rise at score 0x0005 -> score stays 0x0005, state=2, best=0x0005, new_best=1. Next run ending at 0x0003 -> best stays 0x0005, new_best=0.
- OVER alternation (ALT_CYCLES=8), score=3, best=5: disp_val is 0x0003 for 8 cycles, then 0x0005 for 8, repeating. A start pulse -> IDLE with disp_val=0x0005, show_best=1.
- Async reset mid-PLAY: reset=0 between clock edges at score 0x0042 -> all outputs 0 and state=IDLE immediately, without waiting for a clock edge.
